// File: rtl/stick_pkg.sv
// Shared definitions for the channel data scheduler: defaults, tag layout,
// FIFO entry format and scheduler FSM states.
package stick_pkg;

  localparam int unsigned NCH_DEF        = 4;
  localparam int unsigned FIFO_DEPTH_DEF = 16;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned TAG_CH_W  = 2;
  localparam int unsigned TAG_CNT_W = 10;
  localparam int unsigned TAG_W     = TAG_CH_W + TAG_CNT_W;

  // 43-bit FIFO entry: {data, cnt, eof}
  typedef struct packed {
    logic [DATA_W-1:0]    data;
    logic [TAG_CNT_W-1:0] cnt;
    logic                 eof;
  } fifo_entry_t;

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StDrain
  } sched_st_e;

endpackage

// File: rtl/chan_data_sched_if.sv
// Merged output stream of the channel data scheduler (valid/ready handshake).
interface chan_data_sched_if;
  import stick_pkg::*;

  logic [DATA_W-1:0] o_data;
  logic [TAG_W-1:0]  o_tag;
  logic              o_eof;
  logic              o_vld;
  logic              i_rdy;

  modport master (
    output o_data,
    output o_tag,
    output o_eof,
    output o_vld,
    input  i_rdy
  );

  modport slave (
    input  o_data,
    input  o_tag,
    input  o_eof,
    input  o_vld,
    output i_rdy
  );

endinterface

// File: rtl/chan_fifo.sv
// Synchronous show-ahead FIFO for one channel; push while full is legal only
// when a pop happens in the same cycle.
module chan_fifo
  import stick_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
  input  logic        clk20,
  input  logic        res,
  input  logic        push_i,
  input  fifo_entry_t wdata_i,
  input  logic        pop_i,
  output fifo_entry_t rdata_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  fifo_entry_t   mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q;
  logic [AW:0]   rd_ptr_q;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk20) begin
    if (res) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk20) begin
    if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/chan_data_sched.sv
// Merges NCH channel streams record-by-record with a round-robin scheduler.
// Define CHAN_DATA_SCHED_STATS_EN to add saturating dropped-word counters (o_drop_cnt).
module chan_data_sched
  import stick_pkg::*;
#(
  parameter int unsigned NCH        = NCH_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                  clk20,
  input  logic                  res,
  input  logic [32*NCH-1:0]     i_data,
  input  logic [NCH-1:0]        i_vld,
  input  logic [10*NCH-1:0]     i_cnt,
  input  logic [NCH-1:0]        i_cmpl,
  chan_data_sched_if.master     out_bus,
  output logic [NCH-1:0]        o_ovf
`ifdef CHAN_DATA_SCHED_STATS_EN
  ,
  output logic [16*NCH-1:0]     o_drop_cnt
`endif
);

  localparam int unsigned CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  fifo_entry_t wr_entry [NCH];
  fifo_entry_t rd_entry [NCH];
  logic [NCH-1:0] push, pop, full, empty, drop;

  sched_st_e         st_q;
  logic [CH_W-1:0]   rr_q, g_q, next_g, next_rr;
  logic [CH_W:0]     idx_sum;
  logic              found, load;
  logic [DATA_W-1:0] o_data_q;
  logic [TAG_W-1:0]  o_tag_q;
  logic              o_eof_q, o_vld_q;
  logic [NCH-1:0]    ovf_q;

  for (genvar k = 0; k < NCH; k++) begin : g_chan
    // A completion strobe without data becomes an empty eof marker.
    assign wr_entry[k] = i_vld[k] ? {i_data[32*k +: 32], i_cnt[10*k +: 10], i_cmpl[k]}
                                  : {32'h0, 10'h0, 1'b1};
    assign push[k] = (i_vld[k] | i_cmpl[k]) & (~full[k] | pop[k]);
    assign drop[k] = i_vld[k] & full[k] & ~pop[k];

    chan_fifo #(
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk20   (clk20),
      .res     (res),
      .push_i  (push[k]),
      .wdata_i (wr_entry[k]),
      .pop_i   (pop[k]),
      .rdata_o (rd_entry[k]),
      .full_o  (full[k]),
      .empty_o (empty[k])
    );
  end

  // Round-robin search for the first non-empty FIFO starting at rr_q.
  always_comb begin
    found   = 1'b0;
    next_g  = '0;
    idx_sum = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      idx_sum = {1'b0, rr_q} + (CH_W+1)'(i);
      if (idx_sum >= (CH_W+1)'(NCH)) idx_sum = idx_sum - (CH_W+1)'(NCH);
      if (!found && !empty[idx_sum[CH_W-1:0]]) begin
        found  = 1'b1;
        next_g = idx_sum[CH_W-1:0];
      end
    end
  end

  assign next_rr = (g_q == CH_W'(NCH - 1)) ? '0 : g_q + 1'b1;

  // Fetch the next word of the granted record when the output register frees up;
  // a held eof word ends the record, so nothing follows it.
  always_comb begin
    load = 1'b0;
    unique case (st_q)
      StGrant: load = 1'b1;
      StDrain: load = ~empty[g_q] & (~o_vld_q | (out_bus.i_rdy & ~o_eof_q));
      default: load = 1'b0;
    endcase
  end

  always_comb begin
    pop      = '0;
    pop[g_q] = load;
  end

  always_ff @(posedge clk20) begin
    if (res) begin
      st_q     <= StIdle;
      rr_q     <= '0;
      g_q      <= '0;
      o_data_q <= '0;
      o_tag_q  <= '0;
      o_eof_q  <= 1'b0;
      o_vld_q  <= 1'b0;
      ovf_q    <= '0;
    end else begin
      ovf_q <= ovf_q | drop;
      if (load) begin
        o_data_q <= rd_entry[g_q].data;
        o_tag_q  <= {TAG_CH_W'(g_q), rd_entry[g_q].cnt};
        o_eof_q  <= rd_entry[g_q].eof;
        o_vld_q  <= 1'b1;
      end
      unique case (st_q)
        StIdle: begin
          if (found) begin
            g_q  <= next_g;
            st_q <= StGrant;
          end
        end
        StGrant: st_q <= StDrain;
        StDrain: begin
          if (o_vld_q && out_bus.i_rdy && o_eof_q) begin
            o_vld_q <= 1'b0;
            o_eof_q <= 1'b0;
            rr_q    <= next_rr;
            st_q    <= StIdle;
          end else if (!load && out_bus.i_rdy) begin
            // Word taken but the record is not finished: wait on the same channel.
            o_vld_q <= 1'b0;
          end
        end
        default: st_q <= StIdle;
      endcase
    end
  end

  assign out_bus.o_data = o_data_q;
  assign out_bus.o_tag  = o_tag_q;
  assign out_bus.o_eof  = o_eof_q;
  assign out_bus.o_vld  = o_vld_q;
  assign o_ovf          = ovf_q;

`ifdef CHAN_DATA_SCHED_STATS_EN
  logic [15:0] drop_cnt_q [NCH];

  always_ff @(posedge clk20) begin
    for (int k = 0; k < NCH; k++) begin
      if (res) begin
        drop_cnt_q[k] <= '0;
      end else if (drop[k] && (drop_cnt_q[k] != 16'hFFFF)) begin
        drop_cnt_q[k] <= drop_cnt_q[k] + 16'd1;
      end
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_drop_out
    assign o_drop_cnt[16*k +: 16] = drop_cnt_q[k];
  end
`endif

endmodule

// File: tb/tb_chan_data_sched.sv
// Self-checking bench for chan_data_sched: scoreboard of expected output words
// plus per-scenario inline checks.
module tb_chan_data_sched;
  import stick_pkg::*;

  localparam int unsigned NCH = 4;

  logic              clk20 = 1'b0;
  logic              res;
  logic [32*NCH-1:0] i_data;
  logic [NCH-1:0]    i_vld;
  logic [10*NCH-1:0] i_cnt;
  logic [NCH-1:0]    i_cmpl;
  logic [NCH-1:0]    o_ovf;
`ifdef CHAN_DATA_SCHED_STATS_EN
  logic [16*NCH-1:0] o_drop_cnt;
`endif

  chan_data_sched_if bus ();

  typedef struct packed {
    logic [31:0] d;
    logic [11:0] t;
    logic        e;
  } exp_t;

  exp_t sb[$];
  exp_t held[$];
  int   checks = 0;
  int   passed = 0;

  always #5 clk20 = ~clk20;

  chan_data_sched #(
    .NCH        (NCH),
    .FIFO_DEPTH (16)
  ) dut (
    .clk20      (clk20),
    .res        (res),
    .i_data     (i_data),
    .i_vld      (i_vld),
    .i_cnt      (i_cnt),
    .i_cmpl     (i_cmpl),
    .out_bus    (bus),
    .o_ovf      (o_ovf)
`ifdef CHAN_DATA_SCHED_STATS_EN
    ,
    .o_drop_cnt (o_drop_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk20);
    #2;
  endtask

  task automatic clear_in();
    i_data = '0;
    i_vld  = '0;
    i_cnt  = '0;
    i_cmpl = '0;
  endtask

  task automatic sb_add(input int ch, input logic [31:0] d, input logic [9:0] c,
                        input logic v, input logic cm, output exp_t e);
    e.d = v ? d : 32'h0;
    e.t = {ch[1:0], (v ? c : 10'h0)};
    e.e = cm;
  endtask

  // Drive one channel for one clock; optionally record the expected output word.
  task automatic drive1(input int ch, input logic [31:0] d, input logic [9:0] c,
                        input logic v, input logic cm, input logic exp_en);
    exp_t e;
    i_vld[ch]          = v;
    i_cmpl[ch]         = cm;
    i_data[32*ch +: 32] = d;
    i_cnt[10*ch +: 10]  = c;
    if (exp_en) begin
      sb_add(ch, d, c, v, cm, e);
      sb.push_back(e);
    end
    tick();
    clear_in();
  endtask

  task automatic do_reset();
    res = 1'b1;
    tick();
    tick();
    res = 1'b0;
    sb.delete();
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (sb.size() != 0)
      $display("FAIL %s_drain: %0d words still expected after %0d cycles, required 0",
               name, sb.size(), budget);
    else passed++;
    repeat (4) tick();
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk20);
      if (!res && bus.o_vld && bus.i_rdy) begin
        checks++;
        if (sb.size() == 0) begin
          $display("FAIL sb_unexpected: got data=%h tag=%h eof=%0b, required no word",
                   bus.o_data, bus.o_tag, bus.o_eof);
        end else begin
          e = sb.pop_front();
          if ({bus.o_data, bus.o_tag, bus.o_eof} !== {e.d, e.t, e.e})
            $display("FAIL sb_word: got data=%h tag=%h eof=%0b, required data=%h tag=%h eof=%0b",
                     bus.o_data, bus.o_tag, bus.o_eof, e.d, e.t, e.e);
          else passed++;
        end
      end
    end
  endtask

  task automatic test_reset();
    res = 1'b1;
    tick();
    tick();
    @(negedge clk20);
    checks += 5;
    if (bus.o_vld !== 1'b0) $display("FAIL reset_o_vld: got %0b, required 0", bus.o_vld);
    else passed++;
    if (bus.o_eof !== 1'b0) $display("FAIL reset_o_eof: got %0b, required 0", bus.o_eof);
    else passed++;
    if (bus.o_data !== 32'h0) $display("FAIL reset_o_data: got %h, required 0", bus.o_data);
    else passed++;
    if (bus.o_tag !== 12'h0) $display("FAIL reset_o_tag: got %h, required 0", bus.o_tag);
    else passed++;
    if (o_ovf !== 4'h0) $display("FAIL reset_o_ovf: got %b, required 0000", o_ovf);
    else passed++;
    tick();
    res = 1'b0;
    tick();
  endtask

  task automatic test_latency();
    drive1(1, 32'h1111_0000, 10'd0, 1'b1, 1'b0, 1'b1);
    @(negedge clk20);
    checks++;
    if (bus.o_vld !== 1'b0) $display("FAIL lat_cycle0: got o_vld=%0b, required 0", bus.o_vld);
    else passed++;
    drive1(1, 32'h1111_0001, 10'd1, 1'b1, 1'b0, 1'b1);
    @(negedge clk20);
    checks++;
    if (bus.o_vld !== 1'b0) $display("FAIL lat_cycle1: got o_vld=%0b, required 0", bus.o_vld);
    else passed++;
    drive1(1, 32'h1111_0002, 10'd2, 1'b1, 1'b1, 1'b1);
    @(negedge clk20);
    checks++;
    if (bus.o_vld !== 1'b1) $display("FAIL lat_cycle2: got o_vld=%0b, required 1", bus.o_vld);
    else passed++;
    wait_drain(50, "latency");
  endtask

  task automatic test_round_robin();
    exp_t e;
    do_reset();
    for (int w = 0; w < 2; w++) begin
      for (int ch = 0; ch < NCH; ch++) begin
        i_vld[ch]           = 1'b1;
        i_cmpl[ch]          = (w == 1);
        i_data[32*ch +: 32] = 32'hA000_0000 + 32'(ch * 256 + w);
        i_cnt[10*ch +: 10]  = 10'(w);
      end
      tick();
    end
    clear_in();
    for (int ch = 0; ch < NCH; ch++) begin
      for (int w = 0; w < 2; w++) begin
        sb_add(ch, 32'hA000_0000 + 32'(ch * 256 + w), 10'(w), 1'b1, (w == 1), e);
        sb.push_back(e);
      end
    end
    wait_drain(100, "round_robin");
  endtask

  task automatic test_overflow();
    do_reset();
    bus.i_rdy = 1'b0;
    for (int i = 0; i < 18; i++) begin
      drive1(0, 32'hC0DE_0000 + 32'(i), 10'(i), 1'b1, (i == 16), (i < 17));
      if (i == 16) begin
        @(negedge clk20);
        checks++;
        if (o_ovf[0] !== 1'b0) $display("FAIL ovf_at_full: got %0b, required 0", o_ovf[0]);
        else passed++;
      end
    end
    @(negedge clk20);
    checks += 5;
    if (o_ovf[0] !== 1'b1) $display("FAIL ovf_set: got %0b, required 1", o_ovf[0]);
    else passed++;
    if (bus.o_vld !== 1'b1) $display("FAIL ovf_hold_vld: got %0b, required 1", bus.o_vld);
    else passed++;
    if (bus.o_data !== 32'hC0DE_0000)
      $display("FAIL ovf_hold_data: got %h, required c0de0000", bus.o_data);
    else passed++;
    if (bus.o_tag !== 12'h000) $display("FAIL ovf_hold_tag: got %h, required 000", bus.o_tag);
    else passed++;
    if (bus.o_eof !== 1'b0) $display("FAIL ovf_hold_eof: got %0b, required 0", bus.o_eof);
    else passed++;
    tick();
    bus.i_rdy = 1'b1;
    wait_drain(100, "overflow");
    checks++;
    if (o_ovf[0] !== 1'b1) $display("FAIL ovf_sticky: got %0b, required 1", o_ovf[0]);
    else passed++;
  endtask

  task automatic test_stall();
    exp_t e;
    do_reset();
    held.delete();
    i_vld[2] = 1'b1; i_data[64 +: 32] = 32'h2222_0000; i_cnt[20 +: 10] = 10'd0;
    i_vld[3] = 1'b1; i_data[96 +: 32] = 32'h3333_0000; i_cnt[30 +: 10] = 10'd0;
    sb_add(2, 32'h2222_0000, 10'd0, 1'b1, 1'b0, e);
    sb.push_back(e);
    sb_add(3, 32'h3333_0000, 10'd0, 1'b1, 1'b0, e);
    held.push_back(e);
    tick();
    clear_in();
    drive1(3, 32'h3333_0001, 10'd1, 1'b1, 1'b1, 1'b0);
    sb_add(3, 32'h3333_0001, 10'd1, 1'b1, 1'b1, e);
    held.push_back(e);
    repeat (3) tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk20);
      checks++;
      if (bus.o_vld !== 1'b0)
        $display("FAIL stall_wait%0d: got o_vld=%0b tag=%h, required o_vld=0", i, bus.o_vld,
                 bus.o_tag);
      else passed++;
      tick();
    end
    // ch3 words are only expected once ch2 finishes its record.
    sb_add(2, 32'h2222_0001, 10'd1, 1'b1, 1'b1, e);
    sb.push_back(e);
    while (held.size() != 0) sb.push_back(held.pop_front());
    drive1(2, 32'h2222_0001, 10'd1, 1'b1, 1'b1, 1'b0);
    wait_drain(50, "stall");
  endtask

  task automatic test_marker();
    drive1(1, 32'h0, 10'd0, 1'b0, 1'b1, 1'b1);
    wait_drain(50, "marker");
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.i_rdy = 1'b0;
    for (int i = 0; i < 18; i++) drive1(0, 32'hDEAD_0000 + 32'(i), 10'(i), 1'b1, 1'b0, 1'b0);
    @(negedge clk20);
    checks += 2;
    if (o_ovf[0] !== 1'b1) $display("FAIL rmid_pre_ovf: got %0b, required 1", o_ovf[0]);
    else passed++;
    if (bus.o_vld !== 1'b1) $display("FAIL rmid_pre_vld: got %0b, required 1", bus.o_vld);
    else passed++;
    tick();
    res = 1'b1;
    tick();
    res = 1'b0;
    sb.delete();
    @(negedge clk20);
    checks += 2;
    if (bus.o_vld !== 1'b0) $display("FAIL rmid_vld: got %0b, required 0", bus.o_vld);
    else passed++;
    if (o_ovf !== 4'h0) $display("FAIL rmid_ovf: got %b, required 0000", o_ovf);
    else passed++;
    tick();
    bus.i_rdy = 1'b1;
    drive1(0, 32'h5EED_0000, 10'd0, 1'b1, 1'b0, 1'b1);
    drive1(0, 32'h5EED_0001, 10'd1, 1'b1, 1'b1, 1'b1);
    wait_drain(50, "reset_mid");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    res       = 1'b1;
    bus.i_rdy = 1'b1;
    clear_in();
    fork
      monitor();
    join_none
    test_reset();
    test_latency();
    test_round_robin();
    test_overflow();
    test_stall();
    test_marker();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
